// File: rtl/dense_pkg.sv
// Shared definitions for the dense lane engine: FSM state encoding and default geometry.
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NCH_DEF = 16;
    localparam int AW_DEF  = 4;
    localparam int DW_DEF  = 8;

endpackage

// File: rtl/dense_lane_engine_if.sv
// Bus bundle between the dense lane engine (slave) and its controller/memories (master).
interface dense_lane_engine_if
    import dense_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF
);

    logic                start;
    logic [NCH*AW-1:0]   w_raddr;
    logic [NCH*DW-1:0]   w_rdata;
    logic [AW-1:0]       x_raddr;
    logic [DW-1:0]       x_rdata;
    logic [NCH*DW-1:0]   y_data;
    logic                busy;
    logic                finish;

    modport master (
        output start, w_rdata, x_rdata,
        input  w_raddr, x_raddr, y_data, busy, finish
    );

    modport slave (
        input  start, w_rdata, x_rdata,
        output w_raddr, x_raddr, y_data, busy, finish
    );

endinterface

// File: rtl/mac_lane.sv
// One output channel: full-precision multiply-accumulate, then shift, optional ReLU and saturation.
module mac_lane #(
    parameter int DW    = 8,
    parameter int ACCW  = 20,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 post,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);

    localparam logic signed [ACCW-1:0] MAXV = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    logic signed [2*DW-1:0] mul_s;
    logic signed [ACCW-1:0] prod_s;
    logic signed [ACCW-1:0] shifted_s;
    logic signed [DW-1:0]   sat_s;
    logic signed [ACCW-1:0] acc_r;

    // Product widened before accumulation; post-processing of the current accumulator.
    always_comb begin
        mul_s     = w * x;
        prod_s    = ACCW'(mul_s);
        shifted_s = acc_r >>> SHIFT;
        if ((RELU != 0) && shifted_s[ACCW-1]) begin
            sat_s = '0;
        end else if (shifted_s > MAXV) begin
            sat_s = MAXV[DW-1:0];
        end else if (shifted_s < MINV) begin
            sat_s = MINV[DW-1:0];
        end else begin
            sat_s = shifted_s[DW-1:0];
        end
    end

    // Accumulator and result register.
    always_ff @(posedge clk) begin
        if (xrst) begin
            acc_r <= '0;
            y     <= '0;
        end else begin
            if (clr) begin
                acc_r <= '0;
            end else if (en) begin
                acc_r <= acc_r + prod_s;
            end
            if (post) begin
                y <= sat_s;
            end
        end
    end

endmodule

// File: rtl/dense_lane_engine.sv
// Dense layer engine: one shared index drives NCH weight memories and the input memory;
// each lane accumulates its dot product and publishes a saturated result once per pass.
module dense_lane_engine
    import dense_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 16,
    parameter int DW    = DW_DEF,
    parameter int ACCW  = 2 * DW + AW,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             xrst,
    dense_lane_engine_if.slave bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t            state_r;
    logic [AW-1:0]     idx_r;
    logic              busy_r;
    logic              finish_r;
    logic              acc_en_r;
    logic              clr_s;
    logic              post_s;
    logic [NCH*DW-1:0] y_s;

    assign clr_s  = (state_r == ST_IDLE) && bus.start;
    assign post_s = (state_r == ST_POST);

    // Pass sequencer; memory data lags the index by one cycle, hence the delayed accumulate enable.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            acc_en_r <= 1'b0;
        end else begin
            acc_en_r <= (state_r == ST_FETCH);
            case (state_r)
                ST_IDLE: begin
                    finish_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= ST_FETCH;
                        busy_r  <= 1'b1;
                        idx_r   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DRAIN;
                        idx_r   <= '0;
                    end else begin
                        idx_r <= idx_r + AW'(1);
                    end
                end
                ST_DRAIN: state_r <= ST_POST;
                ST_POST: begin
                    state_r  <= ST_DONE;
                    finish_r <= 1'b1;
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    idx_r    <= '0;
                    busy_r   <= 1'b0;
                    finish_r <= 1'b0;
                end
            endcase
        end
    end

    // Index is held at zero outside the fetch phase, so it doubles as the address outputs.
    assign bus.w_raddr = {NCH{idx_r}};
    assign bus.x_raddr = idx_r;
    assign bus.busy    = busy_r;
    assign bus.finish  = finish_r;
    assign bus.y_data  = y_s;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        mac_lane #(
            .DW    (DW),
            .ACCW  (ACCW),
            .SHIFT (SHIFT),
            .RELU  (RELU)
        ) u_lane (
            .clk  (clk),
            .xrst (xrst),
            .clr  (clr_s),
            .en   (acc_en_r),
            .post (post_s),
            .w    (bus.w_rdata[c*DW +: DW]),
            .x    (bus.x_rdata),
            .y    (y_s[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_dense_lane_engine.sv
// Self-checking bench: four engine configurations run side by side against an arithmetic reference.
module tb_dense_lane_engine;
    import dense_pkg::*;

    localparam int NCH = 16;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int NI  = 4;
    localparam int DEP [NI] = '{16, 16, 16, 1};
    localparam int SHF [NI] = '{0, 4, 0, 0};
    localparam int RLU [NI] = '{1, 1, 0, 1};

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    logic signed [DW-1:0] wmem [NCH][16];
    logic signed [DW-1:0] xmem [16];

    logic              start_vec [NI];
    logic [NCH*DW-1:0] y_all     [NI];
    logic              fin_all   [NI];
    logic              busy_all  [NI];
    logic [AW-1:0]     xa_all    [NI];
    logic [NCH*AW-1:0] wa_all    [NI];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_cfg
        dense_lane_engine_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

        dense_lane_engine #(
            .NCH(NCH), .AW(AW), .DEPTH(DEP[g]), .DW(DW),
            .ACCW(2*DW+AW), .SHIFT(SHF[g]), .RELU(RLU[g])
        ) dut (
            .clk  (clk),
            .xrst (xrst),
            .bus  (bus)
        );

        assign bus.start = start_vec[g];
        assign y_all[g]    = bus.y_data;
        assign fin_all[g]  = bus.finish;
        assign busy_all[g] = bus.busy;
        assign xa_all[g]   = bus.x_raddr;
        assign wa_all[g]   = bus.w_raddr;

        // Synchronous-read memories: data valid one cycle after the address.
        always @(posedge clk) begin
            bus.x_rdata <= xmem[bus.x_raddr];
            for (int c = 0; c < NCH; c++)
                bus.w_rdata[c*DW +: DW] <= wmem[c][bus.w_raddr[c*AW +: AW]];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] model_y(input int dep, input int sh, input int relu);
        logic [NCH*DW-1:0] r;
        int acc;
        int v;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            acc = 0;
            for (int k = 0; k < dep; k++) acc += int'(wmem[c][k]) * int'(xmem[k]);
            v = acc >>> sh;
            if (relu != 0 && v < 0) v = 0;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            r[c*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    task automatic fill_const(input logic signed [DW-1:0] wv, input logic signed [DW-1:0] xv);
        for (int k = 0; k < 16; k++) begin
            xmem[k] = xv;
            for (int c = 0; c < NCH; c++) wmem[c][k] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 16; k++) begin
            xmem[k] = DW'($urandom);
            for (int c = 0; c < NCH; c++) wmem[c][k] = DW'($urandom);
        end
    endtask

    task automatic run_pass(input bit repulse, input int rst_at);
        logic [NCH*DW-1:0] exp_y  [NI];
        logic [NCH*DW-1:0] prev_y [NI];
        int fin_cnt [NI];
        int fin_cyc [NI];
        for (int g = 0; g < NI; g++) begin
            exp_y[g]   = model_y(DEP[g], SHF[g], RLU[g]);
            prev_y[g]  = y_all[g];
            fin_cnt[g] = 0;
            fin_cyc[g] = -1;
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) start_vec[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) start_vec[g] = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            for (int g = 0; g < NI; g++)
                if (fin_all[g]) begin
                    fin_cnt[g]++;
                    fin_cyc[g] = cyc;
                end
            if (rst_at == 0 || cyc <= rst_at) begin
                chk("x_raddr", 128'(xa_all[0]), (cyc <= 16) ? 128'(cyc - 1) : 128'(0));
                chk("w_raddr", 128'(wa_all[0]), (cyc <= 16) ? 128'({NCH{4'(cyc - 1)}}) : 128'(0));
                chk("busy", 128'(busy_all[0]), 128'(cyc <= 19));
                chk("x_raddr_d1", 128'(xa_all[3]), 128'(0));
            end
            if (rst_at != 0 && cyc == rst_at + 1)
                for (int g = 0; g < NI; g++) begin
                    chk("rst_y", 128'(y_all[g]), 128'(0));
                    chk("rst_ctl", 128'({wa_all[g], xa_all[g], busy_all[g], fin_all[g]}), 128'(0));
                end
            if (repulse && cyc == 18) chk("y_hold", 128'(y_all[0]), 128'(prev_y[0]));
            for (int g = 0; g < NI; g++)
                start_vec[g] = repulse && (g < 3) && (cyc == 3 || cyc == 10 || cyc == 19);
            xrst = (cyc == rst_at);
            @(negedge clk);
        end
        xrst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            if (rst_at == 0) begin
                chk("fin_count", 128'(fin_cnt[g]), 128'(1));
                chk("fin_cycle", 128'(fin_cyc[g]), 128'(DEP[g] + 3));
                chk("y_model", 128'(y_all[g]), 128'(exp_y[g]));
            end else begin
                chk("fin_after_rst", 128'(fin_cnt[g]), (DEP[g] + 3 <= rst_at) ? 128'(1) : 128'(0));
            end
        end
    endtask

    initial begin
        logic [NCH*DW-1:0] ramp;
        int v;
        xrst = 1'b1;
        for (int g = 0; g < NI; g++) start_vec[g] = 1'b0;
        fill_const(8'sd0, 8'sd0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("reset_y", 128'(y_all[g]), 128'(0));
            chk("reset_ctl", 128'({wa_all[g], xa_all[g], busy_all[g], fin_all[g]}), 128'(0));
        end
        xrst = 1'b0;

        fill_const(8'sd1, 8'sd2);
        run_pass(1'b0, 0);
        chk("ones_x2", 128'(y_all[0]), 128'({NCH{8'd32}}));

        fill_const(8'sd127, 8'sd127);
        run_pass(1'b0, 0);
        chk("max_shift4", 128'(y_all[1]), 128'({NCH{8'd127}}));

        fill_const(-8'sd1, 8'sd5);
        run_pass(1'b0, 0);
        chk("neg_relu", 128'(y_all[0]), 128'(0));
        chk("neg_norelu", 128'(y_all[2]), 128'({NCH{8'hB0}}));

        for (int k = 0; k < 16; k++) begin
            xmem[k] = 8'sd1;
            for (int c = 0; c < NCH; c++) wmem[c][k] = DW'(c);
        end
        run_pass(1'b0, 0);
        for (int c = 0; c < NCH; c++) begin
            v = (16 * c > 127) ? 127 : 16 * c;
            ramp[c*DW +: DW] = v[DW-1:0];
        end
        chk("lane_ramp", 128'(y_all[0]), 128'(ramp));

        fill_rand();
        run_pass(1'b1, 0);

        fill_rand();
        run_pass(1'b0, 8);
        run_pass(1'b0, 0);

        for (int i = 0; i < 4; i++) begin
            fill_rand();
            run_pass(1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
